// File: rtl/loop_tg_pkg.sv
// Shared definitions for the loop-back traffic generator: register map,
// FSM state encodings, NoC header layout and small arithmetic helpers.
package loop_tg_pkg;

  localparam int REG_CTRL     = 'h00;
  localparam int REG_DEST     = 'h04;
  localparam int REG_NUM_PKTS = 'h08;
  localparam int REG_SEED     = 'h0C;
  localparam int REG_STATUS   = 'h10;
  localparam int REG_TX_CNT   = 'h14;
  localparam int REG_RX_CNT   = 'h18;
  localparam int REG_ERR_CNT  = 'h1C;
  localparam int REG_LAST_LAT = 'h20;
  localparam int REG_MAX_LAT  = 'h24;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA, TX_WAIT} tx_state_e;
  typedef enum logic {RX_RH, RX_RD} rx_state_e;

  localparam int HDR_TAG_LSB  = 24;
  localparam int HDR_DEST_LSB = 18;
  localparam int HDR_SEQ_LSB  = 6;
  localparam int HDR_SRC_LSB  = 0;

  function automatic logic [31:0] make_hdr(input logic [7:0] tag, input logic [5:0] dest,
                                           input logic [11:0] seq, input logic [5:0] src);
    logic [31:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 8]  = tag;
    h[HDR_DEST_LSB +: 6] = dest;
    h[HDR_SEQ_LSB +: 12] = seq;
    h[HDR_SRC_LSB +: 6]  = src;
    return h;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/loop_tg_checker.sv
// Echo receive path: header/payload FSM, field compare against the expected
// packet and the round-trip latency counter.
module loop_tg_checker
  import loop_tg_pkg::*;
(
  input  logic        clk_line,
  input  logic        clk_line_rst_low,
  input  logic        wait_i,
  input  logic        lat_start_i,
  input  logic [31:0] exp_hdr_i,
  input  logic [31:0] exp_pay_i,
  input  logic        s_valid_i,
  input  logic [31:0] s_data_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic        resolve_o,
  output logic        match_o,
  output logic        err_o,
  output logic [15:0] lat_o
);

  rx_state_e   state_q;
  logic        ready_q;
  logic        hdr_ok_q;
  logic [15:0] lat_q;
  logic        beat;

  assign beat      = s_valid_i && ready_q;
  assign s_ready_o = ready_q;
  assign lat_o     = lat_q;

  // Pulses are combinational so an echo resolves in the same cycle a timeout would fire.
  always_comb begin
    resolve_o = 1'b0;
    match_o   = 1'b0;
    err_o     = 1'b0;
    if (beat) begin
      if (state_q == RX_RH) begin
        err_o = s_last_i;
      end else if (!s_last_i || !wait_i) begin
        err_o = 1'b1;
      end else begin
        resolve_o = 1'b1;
        match_o   = hdr_ok_q && (s_data_i == exp_pay_i);
        err_o     = !(hdr_ok_q && (s_data_i == exp_pay_i));
      end
    end
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      state_q  <= RX_RH;
      ready_q  <= 1'b0;
      hdr_ok_q <= 1'b0;
      lat_q    <= '0;
    end else begin
      ready_q <= 1'b1;
      if (lat_start_i) begin
        lat_q <= 16'd1;
      end else if (lat_q != 16'hFFFF) begin
        lat_q <= lat_q + 16'd1;
      end
      if (beat) begin
        case (state_q)
          RX_RH: begin
            if (!s_last_i) begin
              state_q  <= RX_RD;
              hdr_ok_q <= (s_data_i == exp_hdr_i);
            end
          end
          default: state_q <= RX_RH;
        endcase
      end
    end
  end

endmodule

// File: rtl/loop_traffic_gen.sv
// Loop-back traffic source: injects header+payload packets one at a time,
// waits for the echo (or a timeout) and keeps counters behind a register map.
module loop_traffic_gen
  import loop_tg_pkg::*;
#(
  parameter int          OFFSET_SZ = 12,
  parameter int          XY_SZ     = 3,
  parameter logic [7:0]  TAG       = 8'hA5,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk_line,
  input  logic        clk_line_rst_low,
  input  logic [5:0]  HsrcId,
  output logic        stream_out_TVALID,
  output logic [31:0] stream_out_TDATA,
  output logic [3:0]  stream_out_TKEEP,
  output logic        stream_out_TLAST,
  input  logic        stream_out_TREADY,
  input  logic        stream_in_TVALID,
  input  logic [31:0] stream_in_TDATA,
  input  logic [3:0]  stream_in_TKEEP,
  input  logic        stream_in_TLAST,
  output logic        stream_in_TREADY,
  input  logic        mem_valid_axi,
  input  logic [31:0] mem_addr_axi,
  input  logic [31:0] mem_wdata_axi,
  input  logic        mem_wstrb_axi,
  output logic [31:0] mem_rdata_axi,
  output logic        irq_done
);

  localparam int ID_W = 2 * XY_SZ;
  localparam int TW   = $clog2(TIMEOUT) + 1;

  tx_state_e       tx_q;
  logic [ID_W-1:0] dest_q;
  logic [15:0]     num_q, seq_q;
  logic [31:0]     seed_q, tdata_q;
  logic [15:0]     tx_cnt_q, rx_cnt_q, err_cnt_q, last_lat_q, max_lat_q;
  logic            done_q, irq_q, tvalid_q, tlast_q;
  logic [TW-1:0]   timer_q;

  logic [OFFSET_SZ-1:0] off;
  logic        wr, start, clear, busy, waiting, hdr_hs, pay_hs, timeout, resolve, last_pkt;
  logic        chk_resolve, chk_match, chk_err;
  logic [15:0] chk_lat;
  logic [31:0] exp_hdr, exp_pay;
  logic [1:0]  err_inc;
  logic        unused_ok;

  assign off      = mem_addr_axi[OFFSET_SZ-1:0];
  assign wr       = mem_valid_axi && mem_wstrb_axi;
  assign start    = wr && (off == OFFSET_SZ'(REG_CTRL)) && mem_wdata_axi[0];
  assign clear    = wr && (off == OFFSET_SZ'(REG_CTRL)) && mem_wdata_axi[1];
  assign busy     = (tx_q != TX_IDLE);
  assign waiting  = (tx_q == TX_WAIT);
  assign hdr_hs   = (tx_q == TX_HDR) && stream_out_TREADY;
  assign pay_hs   = (tx_q == TX_DATA) && stream_out_TREADY;
  assign timeout  = waiting && (timer_q == TW'(TIMEOUT - 1)) && !chk_resolve;
  assign resolve  = chk_resolve || timeout;
  assign last_pkt = ({1'b0, seq_q} + 17'd1) >= {1'b0, num_q};
  // The echo tile swaps the source field for its own ID, which is DEST.
  assign exp_hdr  = make_hdr(TAG, dest_q, seq_q[11:0], dest_q);
  assign exp_pay  = seed_q + {16'b0, seq_q};
  assign err_inc  = {1'b0, chk_err} + {1'b0, timeout};
  assign unused_ok = ^{mem_addr_axi[31:OFFSET_SZ], stream_in_TKEEP};

  assign stream_out_TVALID = tvalid_q;
  assign stream_out_TDATA  = tdata_q;
  assign stream_out_TLAST  = tlast_q;
  assign stream_out_TKEEP  = 4'hF;
  assign irq_done          = irq_q;

  loop_tg_checker u_checker (
    .clk_line         (clk_line),
    .clk_line_rst_low (clk_line_rst_low),
    .wait_i           (waiting),
    .lat_start_i      (hdr_hs),
    .exp_hdr_i        (exp_hdr),
    .exp_pay_i        (exp_pay),
    .s_valid_i        (stream_in_TVALID),
    .s_data_i         (stream_in_TDATA),
    .s_last_i         (stream_in_TLAST),
    .s_ready_o        (stream_in_TREADY),
    .resolve_o        (chk_resolve),
    .match_o          (chk_match),
    .err_o            (chk_err),
    .lat_o            (chk_lat)
  );

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      tx_q     <= TX_IDLE;
      seq_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      irq_q <= 1'b0;
      case (tx_q)
        TX_IDLE: begin
          if (start) begin
            if (num_q == 16'd0) begin
              done_q <= 1'b1;
              irq_q  <= 1'b1;
            end else begin
              done_q   <= 1'b0;
              seq_q    <= '0;
              tx_q     <= TX_HDR;
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b0;
              tdata_q  <= make_hdr(TAG, dest_q, 12'd0, HsrcId);
            end
          end
        end
        TX_HDR: begin
          if (stream_out_TREADY) begin
            tx_q    <= TX_DATA;
            tdata_q <= exp_pay;
            tlast_q <= 1'b1;
          end
        end
        TX_DATA: begin
          if (stream_out_TREADY) begin
            tx_q     <= TX_WAIT;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            timer_q  <= '0;
          end
        end
        TX_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (resolve) begin
            if (last_pkt) begin
              tx_q   <= TX_IDLE;
              done_q <= 1'b1;
              irq_q  <= 1'b1;
            end else begin
              seq_q    <= seq_q + 16'd1;
              tx_q     <= TX_HDR;
              tvalid_q <= 1'b1;
              tdata_q  <= make_hdr(TAG, dest_q, seq_q[11:0] + 12'd1, HsrcId);
            end
          end
        end
        default: tx_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      dest_q <= '0;
      num_q  <= '0;
      seed_q <= '0;
    end else if (wr) begin
      if (off == OFFSET_SZ'(REG_DEST))     dest_q <= mem_wdata_axi[ID_W-1:0];
      if (off == OFFSET_SZ'(REG_NUM_PKTS)) num_q  <= mem_wdata_axi[15:0];
      if (off == OFFSET_SZ'(REG_SEED))     seed_q <= mem_wdata_axi;
    end
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
    end else if (clear) begin
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
    end else begin
      if (pay_hs)          tx_cnt_q  <= sat_add(tx_cnt_q, 2'd1);
      if (chk_resolve)     rx_cnt_q  <= sat_add(rx_cnt_q, 2'd1);
      if (err_inc != 2'd0) err_cnt_q <= sat_add(err_cnt_q, err_inc);
      if (chk_match) begin
        last_lat_q <= chk_lat;
        if (chk_lat > max_lat_q) max_lat_q <= chk_lat;
      end
    end
  end

  always_comb begin
    mem_rdata_axi = '0;
    case (off)
      OFFSET_SZ'(REG_DEST):     mem_rdata_axi = 32'(dest_q);
      OFFSET_SZ'(REG_NUM_PKTS): mem_rdata_axi = 32'(num_q);
      OFFSET_SZ'(REG_SEED):     mem_rdata_axi = seed_q;
      OFFSET_SZ'(REG_STATUS):   mem_rdata_axi = {30'b0, done_q, busy};
      OFFSET_SZ'(REG_TX_CNT):   mem_rdata_axi = 32'(tx_cnt_q);
      OFFSET_SZ'(REG_RX_CNT):   mem_rdata_axi = 32'(rx_cnt_q);
      OFFSET_SZ'(REG_ERR_CNT):  mem_rdata_axi = 32'(err_cnt_q);
      OFFSET_SZ'(REG_LAST_LAT): mem_rdata_axi = 32'(last_lat_q);
      OFFSET_SZ'(REG_MAX_LAT):  mem_rdata_axi = 32'(max_lat_q);
      default:                  mem_rdata_axi = '0;
    endcase
  end

endmodule

// File: doc/loop_traffic_gen.md
# loop_traffic_gen

Traffic source and echo checker for loop-back tiles. Driven by the tile's AXI memory interface, it injects two-beat (header + payload) NoC packets toward one destination tile, consumes the echoed packets, checks them field-by-field, and reports counts and round-trip latency. It sits on the opposite NoC port pair from the echo accelerator: its output stream feeds the echo tile's input path, and the echo tile's output stream returns here.

## Interface
- OFFSET_SZ, 12: register address bits decoded from mem_addr_axi.
- XY_SZ, 3: coordinate width. The header layout below is fixed for 3; other values are unsupported.
- TAG, 8'hA5: header[31:24] of every generated packet.
- TIMEOUT, 1024: cycles to wait for an echo before declaring loss.

- clk_line  in  1  clock. All logic is in this domain.
- clk_line_rst_low  in  1  reset, asynchronous, active-low.
- HsrcId  in  6  own tile ID {y,x}.
- stream_out_TVALID/TDATA/TKEEP/TLAST  out  1/32/4/1  NoC transmit.
- stream_out_TREADY  in  1.
- stream_in_TVALID/TDATA/TKEEP/TLAST  in  1/32/4/1  NoC receive. TKEEP is ignored.
- stream_in_TREADY  out  1.
- mem_valid_axi  in  1.
- mem_addr_axi  in  32.
- mem_wdata_axi  in  32.
- mem_wstrb_axi  in  1: 1 = write, 0 = read.
- mem_rdata_axi  out  32.
- irq_done  out  1: one-cycle pulse when a run completes.

## Operation
- Registers, byte offsets on mem_addr_axi[OFFSET_SZ-1:0]:
  - 0x00 CTRL (W): bit0 start, bit1 clear counters; both self-clear.
  - 0x04 DEST[5:0] (RW).
  - 0x08 NUM_PKTS[15:0] (RW).
  - 0x0C SEED[31:0] (RW).
  - 0x10 STATUS (R): bit0 busy, bit1 done.
  - 0x14 TX_CNT (R).
  - 0x18 RX_CNT (R).
  - 0x1C ERR_CNT (R).
  - 0x20 LAST_LAT (R).
  - 0x24 MAX_LAT (R).
- Register width rules: counters are 16 bits, zero-extended on read. Unmapped offsets read 0; writes to them are ignored. mem_rdata_axi is combinational on mem_addr_axi.
- Packet seq (0 … NUM_PKTS-1):
  - Header = {TAG, DEST, seq[11:0], HsrcId}.
  - Payload = SEED + seq, mod 2^32.
- TX FSM:
  - IDLE → HDR on start when not busy. Start while busy is ignored.
  - HDR → DATA on header handshake.
  - DATA → WAIT on payload handshake, which carries TLAST=1. TX_CNT increments on this handshake.
  - WAIT → HDR (next seq) or IDLE (last seq) when the checker resolves the packet: echo received, or timeout.
  - Only one packet is outstanding at a time, because the echo tile holds one packet.
- Expected echo: header = {TAG, DEST, seq[11:0], DEST}, payload = SEED + seq.
- Checker FSM: RH (expect header) ↔ RD (expect payload).
  - A header beat with TLAST=1 is malformed: ERR+1, stay in RH.
  - A payload beat with TLAST=0 is malformed: ERR+1, return to RH.
  - A complete echo in WAIT that matches: RX+1, latency update.
  - A complete echo in WAIT that mismatches: RX+1, ERR+1, still resolves WAIT.
  - An echo arriving outside WAIT (late or stale): ERR+1 only.
- Timeout: no resolution within TIMEOUT cycles of entering WAIT → ERR+1, resolve.
- NUM_PKTS=0: start sets done and pulses irq_done next cycle; nothing is sent.
- Clear while busy zeroes the counters; the run continues.
- Start clears done.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - stream_out_TVALID=0, TDATA=0, TLAST=0.
  - TKEEP constant 4'hF.
  - stream_in_TREADY=0; it is 1 from the first clock after reset release.
  - irq_done=0.
  - All registers and counters 0.
- Output handshake: TVALID/TDATA/TLAST are registered and held stable until TREADY. TVALID never deasserts without a handshake.
- Latency:
  - First header is valid 1 cycle after the start write.
  - Payload is valid the cycle after the header handshake.
  - The next packet's header is valid 1 cycle after resolution.
  - Latency counter starts at the header handshake and stops at the echo payload beat. It saturates at 16'hFFFF.
  - LAST_LAT and MAX_LAT update 1 cycle later.
- Simultaneous timeout and matching echo in the same cycle: the echo wins; no ERR.
- Reset mid-run: all state returns to reset values. Any echo arriving afterward is counted as stale.

## Structure
- loop_tg_pkg holds: register offsets, TX/RX state enums, header field bit positions.
- Sub-module loop_tg_checker holds the RX FSM, compare, and latency capture. It takes the expected header/payload and a wait flag, and returns resolve/err/match pulses.

## Test plan
- Basic run: DEST=6'h09, SEED=32'h100, NUM=3, ideal echo model → payloads 0x100..0x102; TX=RX=3, ERR=0; irq_done pulses once.
- Backpressure: stream_out_TREADY toggled 1-in-3 → TDATA stable while stalled; counts unchanged from basic run.
- Corrupt echo: payload^1 on seq 1 → RX=3, ERR=1; run completes.
- Echo drop: seq 0 never echoed, TIMEOUT=16 → ERR=1 after 16 cycles in WAIT. A late echo injected afterward → ERR=2.
- Malformed: header beat with TLAST=1 → ERR+1; checker stays in RH; next valid echo matches.
- Edge cases:
  - NUM=0 → done, no TVALID.
  - Start while busy → ignored.
  - Reset asserted mid-DATA → TVALID=0 immediately.
